// File: rtl/sqrt_iter_core.sv
// Iterative restoring square root: one root bit per clock, fixed latency of WIDTH/2+2 cycles from start.
// Optional remainder output enabled by defining SQRT_REMAINDER_EN.
module sqrt_iter_core #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy
`ifdef SQRT_REMAINDER_EN
  ,
  output logic [WIDTH/2:0] rem
`endif
);

  localparam int N  = WIDTH / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_init_q;
  logic             r_armed;
  logic [WIDTH-1:0] r_rad;
  logic [WIDTH-1:0] w_rad_next;
  logic [N+1:0]     r_acc;
  logic [N+1:0]     w_acc_next;
  logic [N-1:0]     r_root;
  logic [N-1:0]     w_root_next;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_next;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_result_next;
  logic             r_done;
  logic             w_done_next;
`ifdef SQRT_REMAINDER_EN
  logic [N:0]       r_rem;
  logic [N:0]       w_rem_next;
`endif

  logic             w_start;
  logic [N+3:0]     w_acc_shift;
  logic [N+1:0]     w_trial;
  logic             w_ge;
  logic [N+1:0]     w_acc_sub;

  // r_armed blocks a start on the first edge after reset release, so init held high through reset
  // cannot launch an operation until it has been seen low with reset inactive.
  assign w_start     = init & ~r_init_q & r_armed;
  assign w_acc_shift = {r_acc, r_rad[WIDTH-1:WIDTH-2]};
  assign w_trial     = {r_root, 2'b01};
  assign w_ge        = (w_acc_shift >= {2'b00, w_trial});
  assign w_acc_sub   = w_acc_shift[N+1:0] - w_trial;

  always_comb begin
    w_state_next  = r_state;
    w_rad_next    = r_rad;
    w_acc_next    = r_acc;
    w_root_next   = r_root;
    w_cnt_next    = r_cnt;
    w_result_next = r_result;
    w_done_next   = r_done;
`ifdef SQRT_REMAINDER_EN
    w_rem_next    = r_rem;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_next = S_LOAD;
      end
      S_LOAD: begin
        w_rad_next   = A;
        w_acc_next   = '0;
        w_root_next  = '0;
        w_cnt_next   = CW'(N - 1);
        w_done_next  = 1'b0;
        w_state_next = S_CALC;
      end
      S_CALC: begin
        w_rad_next = {r_rad[WIDTH-3:0], 2'b00};
        if (w_ge) begin
          w_acc_next  = w_acc_sub;
          w_root_next = {r_root[N-2:0], 1'b1};
        end else begin
          w_acc_next  = w_acc_shift[N+1:0];
          w_root_next = {r_root[N-2:0], 1'b0};
        end
        if (r_cnt == '0) w_state_next = S_DONE;
        else             w_cnt_next   = r_cnt - CW'(1);
      end
      S_DONE: begin
        w_result_next = {{(WIDTH-N){1'b0}}, r_root};
`ifdef SQRT_REMAINDER_EN
        w_rem_next    = r_acc[N:0];
`endif
        w_done_next   = 1'b1;
        w_state_next  = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_init_q <= 1'b0;
      r_armed  <= 1'b0;
      r_rad    <= '0;
      r_acc    <= '0;
      r_root   <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
`ifdef SQRT_REMAINDER_EN
      r_rem    <= '0;
`endif
    end else begin
      r_state  <= w_state_next;
      r_init_q <= init;
      r_armed  <= 1'b1;
      r_rad    <= w_rad_next;
      r_acc    <= w_acc_next;
      r_root   <= w_root_next;
      r_cnt    <= w_cnt_next;
      r_result <= w_result_next;
      r_done   <= w_done_next;
`ifdef SQRT_REMAINDER_EN
      r_rem    <= w_rem_next;
`endif
    end
  end

  assign result = r_result;
  assign done   = r_done;
  assign busy   = (r_state == S_LOAD) || (r_state == S_CALC);
`ifdef SQRT_REMAINDER_EN
  assign rem    = r_rem;
`endif

endmodule
